// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding request FSM, 1-entry skid buffer
// and the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush_id,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_pending
);

    typedef enum logic [1:0] {StReq, StWait, StDrop} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        grant;
    logic        deliver;

    assign imem_req      = (state_q == StReq) && !stall_if && !buf_valid_q && !rst;
    assign imem_addr     = pc_q;
    assign fetch_pending = (state_q != StReq);
    assign id_valid      = id_valid_q;
    assign id_instr      = id_instr_q;
    assign id_pc         = id_pc_q;

    assign grant   = imem_req && imem_gnt;
    // A response is only useful if no redirect or flush kills it in the same cycle.
    assign deliver = (state_q == StWait) && imem_rvalid && !branch_taken && !flush_id;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        unique case (state_q)
            StReq: begin
                if (grant) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = branch_taken ? StDrop : StWait;
                end
            end
            StWait: begin
                if (imem_rvalid)       state_d = StReq;
                else if (branch_taken) state_d = StDrop;
            end
            StDrop: begin
                if (imem_rvalid) state_d = StReq;
            end
            default: state_d = StReq;
        endcase
        if (branch_taken) pc_d = branch_target;
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (branch_taken) begin
            buf_valid_d = 1'b0;
        end else if (buf_valid_q && !stall_id) begin
            buf_valid_d = 1'b0;
        end else if (deliver && stall_id) begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata;
            buf_pc_d    = req_pc_q;
        end

        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (flush_id) begin
            id_valid_d = 1'b0;
        end else if (stall_id) begin
            id_valid_d = id_valid_q;
        end else if (buf_valid_q) begin
            id_valid_d = 1'b1;
            id_instr_d = buf_instr_q;
            id_pc_d    = buf_pc_q;
        end else if (deliver) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = req_pc_q;
        end else begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StReq;
            pc_q        <= RESET_VECTOR;
            req_pc_q    <= 32'h0;
            buf_valid_q <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 32'h0;
            id_valid_q  <= 1'b0;
            id_instr_q  <= 32'h0;
            id_pc_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, reset/wrap sequences and a randomized
// memory responder checked against an in-order instruction stream model.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst, stall_if, stall_id, flush_id, branch_taken;
    logic [31:0] branch_target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        id_valid, fetch_pending;
    logic [31:0] id_instr, id_pc;

    logic        w_rst, w_gnt, w_rvalid;
    logic [31:0] w_rdata;
    logic        w_req, w_id_valid, w_pend;
    logic [31:0] w_addr, w_id_instr, w_id_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .fetch_pending(fetch_pending)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(w_rst), .stall_if(1'b0), .stall_id(1'b0),
        .flush_id(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .id_valid(w_id_valid),
        .id_instr(w_id_instr), .id_pc(w_id_pc), .fetch_pending(w_pend)
    );

    typedef struct {
        logic        rst, sif, sid, fl, br;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic        req;
        logic [31:0] addr;
        logic        pend, idv;
        logic [31:0] idpc;
        logic        bufv;
    } vec_t;

    function automatic vec_t mk(logic r, logic si, logic sd, logic f, logic b, logic [31:0] t,
                                logic g, logic v, logic rq, logic [31:0] a, logic p,
                                logic iv, logic [31:0] ip, logic bv);
        vec_t x;
        x.rst = r; x.sif = si; x.sid = sd; x.fl = f; x.br = b; x.tgt = t;
        x.gnt = g; x.rv = v; x.req = rq; x.addr = a; x.pend = p; x.idv = iv;
        x.idpc = ip; x.bufv = bv;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t        tv[24];
    logic [31:0] gaddr, oaddr, exp_fetch, exp_id, req_addr;
    logic        outstanding, granted;
    int          lat, consumed;

    initial begin
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; flush_id = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        w_rst = 1'b1; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
        gaddr = 32'h0;

        //          rst si sd fl br tgt      g  v  req addr     p  iv idpc     bv
        tv[0]  = mk(1, 0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   0);
        tv[1]  = mk(0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 32'h0,   0, 0, 32'h0,   0);
        tv[2]  = mk(0, 0, 0, 0, 0, 32'h0,   1, 1, 0, 32'h4,   1, 0, 32'h0,   0);
        tv[3]  = mk(0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 32'h4,   0, 1, 32'h0,   0);
        tv[4]  = mk(0, 0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h8,   1, 0, 32'h0,   0);
        tv[5]  = mk(0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 32'h8,   0, 1, 32'h4,   0);
        tv[6]  = mk(0, 0, 1, 0, 0, 32'h0,   0, 1, 0, 32'hC,   1, 0, 32'h4,   0);
        tv[7]  = mk(0, 0, 1, 0, 0, 32'h0,   1, 0, 0, 32'hC,   0, 0, 32'h4,   1);
        tv[8]  = mk(0, 0, 0, 0, 0, 32'h0,   1, 0, 0, 32'hC,   0, 0, 32'h4,   1);
        tv[9]  = mk(0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 32'hC,   0, 1, 32'h8,   0);
        tv[10] = mk(0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 32'h10,  1, 0, 32'h8,   0);
        tv[11] = mk(0, 0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h100, 1, 0, 32'h8,   0);
        tv[12] = mk(0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 32'h100, 0, 0, 32'h8,   0);
        tv[13] = mk(0, 0, 0, 0, 1, 32'h200, 0, 1, 0, 32'h104, 1, 0, 32'h8,   0);
        tv[14] = mk(0, 1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h200, 0, 0, 32'h8,   0);
        tv[15] = mk(0, 1, 0, 0, 0, 32'h0,   1, 0, 0, 32'h200, 0, 0, 32'h8,   0);
        tv[16] = mk(0, 1, 0, 0, 0, 32'h0,   1, 0, 0, 32'h200, 0, 0, 32'h8,   0);
        tv[17] = mk(0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 32'h200, 0, 0, 32'h8,   0);
        tv[18] = mk(0, 0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h204, 1, 0, 32'h8,   0);
        tv[19] = mk(0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 32'h204, 0, 1, 32'h200, 0);
        tv[20] = mk(0, 0, 0, 1, 0, 32'h0,   0, 1, 0, 32'h208, 1, 0, 32'h200, 0);
        tv[21] = mk(0, 0, 0, 0, 1, 32'h300, 1, 0, 1, 32'h208, 0, 0, 32'h200, 0);
        tv[22] = mk(0, 0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h300, 1, 0, 32'h200, 0);
        tv[23] = mk(0, 0, 0, 0, 0, 32'h0,   0, 0, 1, 32'h300, 0, 0, 32'h200, 0);

        step();
        for (int i = 0; i < 24; i++) begin
            rst = tv[i].rst; stall_if = tv[i].sif; stall_id = tv[i].sid;
            flush_id = tv[i].fl; branch_taken = tv[i].br; branch_target = tv[i].tgt;
            imem_gnt = tv[i].gnt; imem_rvalid = tv[i].rv; imem_rdata = gaddr ^ K;
            #1;
            chk($sformatf("row%0d_req", i), imem_req, tv[i].req);
            chk($sformatf("row%0d_addr", i), imem_addr, tv[i].addr);
            chk($sformatf("row%0d_pend", i), fetch_pending, tv[i].pend);
            chk($sformatf("row%0d_idv", i), id_valid, tv[i].idv);
            chk($sformatf("row%0d_idpc", i), id_pc, tv[i].idpc);
            chk($sformatf("row%0d_buf", i), dut.buf_valid_q, tv[i].bufv);
            if (tv[i].idv) chk($sformatf("row%0d_instr", i), id_instr, tv[i].idpc ^ K);
            if (imem_req && imem_gnt) gaddr = imem_addr;
            step();
        end
        stall_if = 1'b0; stall_id = 1'b0; flush_id = 1'b0; branch_taken = 1'b0;
        imem_rvalid = 1'b0;

        // Reset while a request is outstanding: the stale response must be ignored.
        imem_gnt = 1'b1;
        #1 chk("rst_out_req", imem_req, 1'b1);
        step();
        rst = 1'b1; imem_gnt = 1'b0;
        step();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h300 ^ K;
        #1;
        chk("rst_first_req", imem_req, 1'b1);
        chk("rst_first_addr", imem_addr, 32'h0);
        chk("rst_pend", fetch_pending, 1'b0);
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("rst_stale_idv", id_valid, 1'b0);
        chk("rst_stale_pend", fetch_pending, 1'b0);
        chk("rst_still_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0 ^ K;
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("rst_fresh_idv", id_valid, 1'b1);
        chk("rst_fresh_idpc", id_pc, 32'h0);
        chk("rst_fresh_instr", id_instr, K);

        // Randomized run against an in-order stream model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        outstanding = 1'b0; lat = 0; oaddr = 32'h0;
        exp_fetch = 32'h0; exp_id = 32'h0; consumed = 0;
        for (int c = 0; c < 1500; c++) begin
            stall_if    = ($urandom_range(0, 99) < 15);
            stall_id    = ($urandom_range(0, 99) < 25);
            imem_gnt    = ($urandom_range(0, 99) < 70);
            imem_rvalid = outstanding && (lat == 0);
            imem_rdata  = oaddr ^ K;
            #1;
            granted  = imem_req && imem_gnt;
            req_addr = imem_addr;
            if (imem_req) begin
                chk("rand_addr", imem_addr, exp_fetch);
                chk("rand_one_outstanding", outstanding, 1'b0);
            end
            if (id_valid && !stall_id) begin
                chk("rand_id_pc", id_pc, exp_id);
                chk("rand_id_instr", id_instr, exp_id ^ K);
                exp_id += 32'd4;
                consumed++;
            end
            @(posedge clk);
            if (imem_rvalid) outstanding = 1'b0;
            else if (outstanding && lat > 0) lat--;
            if (granted) begin
                outstanding = 1'b1;
                oaddr       = req_addr;
                lat         = $urandom_range(0, 2);
                exp_fetch  += 32'd4;
            end
            @(negedge clk);
        end
        chk("rand_progress", 32'(consumed >= 100), 32'd1);
        stall_if = 1'b0; stall_id = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;

        // Address wrap from the top of the address space.
        w_rst = 1'b0;
        #1;
        chk("wrap_first_req", w_req, 1'b1);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        w_gnt = 1'b1;
        step();
        w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hFFFF_FFFC ^ K;
        #1 chk("wrap_pend", w_pend, 1'b1);
        step();
        w_rvalid = 1'b0;
        #1;
        chk("wrap_second_req", w_req, 1'b1);
        chk("wrap_second_addr", w_addr, 32'h0);
        chk("wrap_idv", w_id_valid, 1'b1);
        chk("wrap_idpc", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", w_id_instr, 32'hFFFF_FFFC ^ K);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 stall_if  input  1  from hazard unit; blocks issue of a new fetch request.
REQ-005 stall_id  input  1  from hazard unit; holds the IF/ID register contents.
REQ-006 flush_id  input  1  from hazard unit; invalidates the IF/ID register.
REQ-007 branch_taken  input  1  one-cycle redirect pulse from EX.
REQ-008 branch_target  input  32  redirect PC, sampled when branch_taken=1.
REQ-009 imem_req  output  1  fetch request valid.
REQ-010 imem_addr  output  32  fetch address, equal to pc while imem_req=1.
REQ-011 imem_gnt  input  1  request accepted when imem_req&&imem_gnt.
REQ-012 imem_rvalid  input  1  response valid, at least 1 cycle after grant.
REQ-013 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-014 id_valid  output  1  IF/ID register holds a live instruction.
REQ-015 id_instr  output  32  IF/ID instruction.
REQ-016 id_pc  output  32  address of id_instr.
REQ-017 fetch_pending  output  1  high while a request is outstanding (state WAIT or DROP).

Function
REQ-018 States REQ, WAIT and DROP shall be used, with at most one request outstanding.
REQ-019 imem_req shall be (state==REQ) && !stall_if && !buf_valid.
REQ-020 In REQ, on grant without branch_taken, the unit shall set req_pc<=pc and pc<=pc+4 (mod 2^32), then go to WAIT.
REQ-021 In WAIT, on imem_rvalid, the unit shall go to REQ and deliver {imem_rdata, req_pc} per REQ-023/024.
REQ-022 In DROP, on imem_rvalid, the unit shall discard the response and go to REQ.
REQ-023 Delivery with !stall_id and !flush_id shall load IF/ID the next edge and set id_valid=1.
REQ-024 Delivery with stall_id=1 shall capture the response in a 1-entry skid buffer (buf_valid=1), leaving IF/ID unchanged.
REQ-025 With buf_valid=1 and !stall_id, the buffer shall move to IF/ID and clear buf_valid the same edge.
REQ-026 IF/ID update priority shall be: rst > flush_id (id_valid<=0) > stall_id (hold) > buffer/response load > bubble (id_valid<=0).
REQ-027 branch_taken shall set pc<=branch_target and clear buf_valid, with priority over the pc+4 increment.
REQ-028 branch_taken in WAIT without rvalid, or in REQ with a same-cycle grant, shall move the unit to DROP.
REQ-029 branch_taken in WAIT with a same-cycle rvalid shall discard that response and move the unit to REQ.
REQ-030 branch_taken in DROP shall update pc and keep the unit in DROP.
REQ-031 flush_id with rvalid in WAIT shall discard the response and leave the IF/ID register invalid.
REQ-032 id_instr and id_pc shall retain their last values while id_valid=0.
REQ-033 The address shall wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no error.

Reset
REQ-034 While rst=1, the unit shall hold pc=RESET_VECTOR, state=REQ, buf_valid=0, id_valid=0, id_instr=0, id_pc=0, imem_req=0, fetch_pending=0.
REQ-035 After rst with an outstanding request, the unit shall ignore any later imem_rvalid until its next grant.
REQ-036 The first request shall issue in the first cycle after rst deasserts.

Verification
REQ-037 Streaming: the bench shall model gnt=1 with rvalid 1 cycle later, data=addr^32'hA5A5_A5A5, and check that id_pc steps 0, 4, 8 with matching id_instr and one bubble between instructions.
REQ-038 Stall skid: the bench shall assert stall_id during the rvalid for pc 8, then check buf_valid=1, IF/ID held at pc 4, and id_pc=8 one cycle after stall_id drops.
REQ-039 Redirect while outstanding: the bench shall pulse branch_taken with target 32'h100 in WAIT, and check that the late response is dropped and the next imem_addr is 32'h100.
REQ-040 Simultaneous events: the bench shall drive branch_taken with rvalid in the same cycle, and check that nothing is delivered, the state is REQ, and imem_addr is the target the next cycle.
REQ-041 stall_if: the bench shall hold stall_if=1 for 3 cycles, and check that imem_req=0, pc is unchanged, and issue resumes on release.
REQ-042 Wrap: the bench shall set RESET_VECTOR=32'hFFFF_FFFC, and check that the second fetch address is 32'h0000_0000.
